// File: rtl/ramb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ramb_port_arbiter
//  Purpose  : Shares port-B of the upper-RAM dual-port block among NUM_REQ
//             requesters (AdamNet DMA, disk track loader, debug reader).
//             Round-robin grant, one outstanding access, strobe/ack handshake,
//             watchdog completion when the memory ack never arrives.
//  Ports    : clk_i/reset_n_i      clock, async active-low reset
//             req_rd_i/req_wr_i    per-requester level requests
//             req_addr_i/req_data_i packed per-requester address / write data
//             req_ack_o/req_err_o  completion pulse (+ timeout flag)
//             req_data_o           read data, held after completion
//             grant_o/busy_o       current grant index, not-idle flag
//             ramb_*               port-B strobes, address, data, acks
//  Revision : 1.0  initial release
// ============================================================================
module ramb_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [NUM_REQ-1:0]         req_rd_i,
  input  logic [NUM_REQ-1:0]         req_wr_i,
  input  logic [NUM_REQ*AW-1:0]      req_addr_i,
  input  logic [NUM_REQ*DW-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic                       req_err_o,
  output logic [DW-1:0]              req_data_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic [AW-1:0]              ramb_addr_o,
  output logic                       ramb_rd_o,
  output logic                       ramb_wr_o,
  output logic [DW-1:0]              ramb_dout_o,
  input  logic [DW-1:0]              ramb_din_i,
  input  logic                       ramb_rd_ack_i,
  input  logic                       ramb_wr_ack_i
);

  localparam int         GW  = $clog2(NUM_REQ);
  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q;
  logic [GW-1:0]        ptr_q;
  logic [GW-1:0]        grant_q;
  logic                 dir_q;      // 1 = write
  logic [7:0]           wd_q;
  logic [AW-1:0]        ramb_addr_q;
  logic [DW-1:0]        ramb_dout_q;
  logic                 ramb_rd_q;
  logic                 ramb_wr_q;
  logic [NUM_REQ-1:0]   req_ack_q;
  logic                 req_err_q;
  logic [DW-1:0]        req_data_q;

  logic [AW-1:0]        addr_arr [NUM_REQ];
  logic [DW-1:0]        data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   pend;
  logic                 any_d;
  logic [GW-1:0]        gnt_d;
  logic [GW-1:0]        ptr_d;
  logic [GW-1:0]        idx_s;
  int                   idx_v;
  logic [NUM_REQ-1:0]   ack_onehot;
  logic                 mem_ack;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr_i[gi*AW +: AW];
    assign data_arr[gi] = req_data_i[gi*DW +: DW];
  end

  assign pend = req_rd_i | req_wr_i;

  // Round-robin search from ptr_q upward. Scanning from the far end down
  // lets the closest pending index overwrite earlier hits.
  always_comb begin
    any_d = 1'b0;
    gnt_d = '0;
    idx_v = 0;
    idx_s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_v = int'(ptr_q) + k;
      if (idx_v >= NUM_REQ) idx_v = idx_v - NUM_REQ;
      idx_s = GW'(idx_v);
      if (pend[idx_s]) begin
        any_d = 1'b1;
        gnt_d = idx_s;
      end
    end
  end

  assign ptr_d      = (gnt_d == GW'(NUM_REQ - 1)) ? '0 : gnt_d + GW'(1);
  assign ack_onehot = NUM_REQ'(1) << grant_q;
  // Only the ack matching the latched direction counts.
  assign mem_ack    = dir_q ? ramb_wr_ack_i : ramb_rd_ack_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      dir_q       <= 1'b0;
      wd_q        <= '0;
      ramb_addr_q <= '0;
      ramb_dout_q <= '0;
      ramb_rd_q   <= 1'b0;
      ramb_wr_q   <= 1'b0;
      req_ack_q   <= '0;
      req_err_q   <= 1'b0;
      req_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            grant_q     <= gnt_d;
            ptr_q       <= ptr_d;
            ramb_addr_q <= addr_arr[gnt_d];
            ramb_dout_q <= data_arr[gnt_d];
            // Read and write together resolve to a write.
            dir_q       <= req_wr_i[gnt_d];
            ramb_wr_q   <= req_wr_i[gnt_d];
            ramb_rd_q   <= ~req_wr_i[gnt_d];
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ramb_rd_q <= 1'b0;
          ramb_wr_q <= 1'b0;
          wd_q      <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_ack) begin
            if (!dir_q) req_data_q <= ramb_din_i;
            req_ack_q <= ack_onehot;
            req_err_q <= 1'b0;
            state_q   <= S_DONE;
          end else if (wd_q + 8'd1 == TO8) begin
            if (!dir_q) req_data_q <= '1;
            req_ack_q <= ack_onehot;
            req_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            wd_q <= wd_q + 8'd1;
          end
        end
        S_DONE: begin
          // Dead cycle: the requester drops its level while we sit here,
          // so IDLE never sees a stale request from the finished access.
          req_ack_q <= '0;
          req_err_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ack_o   = req_ack_q;
  assign req_err_o   = req_err_q;
  assign req_data_o  = req_data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != S_IDLE);
  assign ramb_addr_o = ramb_addr_q;
  assign ramb_rd_o   = ramb_rd_q;
  assign ramb_wr_o   = ramb_wr_q;
  assign ramb_dout_o = ramb_dout_q;

endmodule
`default_nettype wire

// File: tb/tb_ramb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ramb_port_arbiter
//  Purpose  : Self-checking bench for ramb_port_arbiter with a port-B memory
//             model that acks one cycle after each strobe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ramb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_rd = '0;
  logic [2:0]  req_wr = '0;
  logic [47:0] req_addr = '0;
  logic [23:0] req_data = '0;
  logic [2:0]  req_ack;
  logic        req_err;
  logic [7:0]  req_dout;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] ramb_addr;
  logic        ramb_rd;
  logic        ramb_wr;
  logic [7:0]  ramb_dout;
  logic [7:0]  m_din = '0;
  logic        m_rd_ack = 1'b0;
  logic        m_wr_ack = 1'b0;
  logic        inj_rd_ack = 1'b0;
  logic        inj_wr_ack = 1'b0;
  logic        mem_ack_en = 1'b1;
  logic [7:0]  mem [0:65535];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ramb_port_arbiter #(.NUM_REQ(3), .AW(16), .DW(8), .TIMEOUT(15)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_rd_i     (req_rd),
    .req_wr_i     (req_wr),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ack_o    (req_ack),
    .req_err_o    (req_err),
    .req_data_o   (req_dout),
    .grant_o      (grant),
    .busy_o       (busy),
    .ramb_addr_o  (ramb_addr),
    .ramb_rd_o    (ramb_rd),
    .ramb_wr_o    (ramb_wr),
    .ramb_dout_o  (ramb_dout),
    .ramb_din_i   (m_din),
    .ramb_rd_ack_i(m_rd_ack | inj_rd_ack),
    .ramb_wr_ack_i(m_wr_ack | inj_wr_ack)
  );

  // Console memory: registered ack one cycle after the strobe.
  always @(posedge clk) begin
    if (ramb_wr) mem[ramb_addr] <= ramb_dout;
    m_rd_ack <= ramb_rd & mem_ack_en;
    m_wr_ack <= ramb_wr & mem_ack_en;
    m_din    <= mem[ramb_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    int          idx;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_data;
  } vec_t;

  // Single access; called on a negedge with the DUT idle.
  task automatic do_access(input vec_t v);
    logic exp_wr, exp_rd;
    exp_wr = v.wr;
    exp_rd = v.rd & ~v.wr;
    req_rd[v.idx] = v.rd;
    req_wr[v.idx] = v.wr;
    req_addr[v.idx*16 +: 16] = v.addr;
    req_data[v.idx*8 +: 8]   = v.wdata;
    @(negedge clk);
    chk("strobe_rd", ramb_rd, exp_rd);
    chk("strobe_wr", ramb_wr, exp_wr);
    chk("strobe_addr", ramb_addr, v.addr);
    chk("grant", grant, v.idx);
    if (exp_wr) chk("strobe_dout", ramb_dout, v.wdata);
    @(negedge clk);
    chk("wait_strobes", {ramb_rd, ramb_wr}, 2'b00);
    chk("wait_busy", busy, 1'b1);
    @(negedge clk);
    chk("ack_vec", req_ack, 3'b001 << v.idx);
    chk("ack_err", req_err, 1'b0);
    if (exp_rd) chk("rd_data", req_dout, v.exp_data);
    req_rd[v.idx] = 1'b0;
    req_wr[v.idx] = 1'b0;
    @(negedge clk);
    chk("after_ack", req_ack, 3'b000);
    chk("after_busy", busy, 1'b0);
    if (exp_wr) chk("mem_write", mem[v.addr], v.wdata);
  endtask

  vec_t       tbl [8];
  logic [2:0] rr_exp [4];
  int         n_ack;
  int         ack_c;
  bit         found;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

    tbl[0] = '{rd:1'b0, wr:1'b1, idx:0, addr:16'h0010, wdata:8'h11, exp_data:8'h00};
    tbl[1] = '{rd:1'b0, wr:1'b1, idx:1, addr:16'h1234, wdata:8'hA5, exp_data:8'h00};
    tbl[2] = '{rd:1'b1, wr:1'b0, idx:1, addr:16'h1234, wdata:8'h00, exp_data:8'hA5};
    tbl[3] = '{rd:1'b1, wr:1'b1, idx:2, addr:16'h0100, wdata:8'h3C, exp_data:8'h00};
    tbl[4] = '{rd:1'b1, wr:1'b0, idx:0, addr:16'h0100, wdata:8'h00, exp_data:8'h3C};
    tbl[5] = '{rd:1'b1, wr:1'b0, idx:2, addr:16'h0010, wdata:8'h00, exp_data:8'h11};
    tbl[6] = '{rd:1'b0, wr:1'b1, idx:1, addr:16'hFFFF, wdata:8'h5A, exp_data:8'h00};
    tbl[7] = '{rd:1'b1, wr:1'b0, idx:0, addr:16'hFFFF, wdata:8'h00, exp_data:8'h5A};
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    // Reset state, with all three write requests already held.
    req_wr   = 3'b111;
    req_addr = {16'hA002, 16'hA001, 16'hA000};
    req_data = {8'h32, 8'h21, 8'h10};
    @(negedge clk);
    @(negedge clk);
    chk("rst_outputs", {req_ack, req_err, req_dout, grant, busy}, '0);
    chk("rst_ramb", {ramb_addr, ramb_rd, ramb_wr, ramb_dout}, '0);

    // Round robin: grants 0,1,2,0, acks 4 cycles apart.
    reset_n = 1'b1;
    n_ack = 0;
    for (int c = 1; c <= 30 && n_ack < 4; c++) begin
      @(negedge clk);
      if (req_ack != 3'b000) begin
        chk("rr_ack_vec", req_ack, rr_exp[n_ack]);
        chk("rr_ack_cycle", c, 3 + 4 * n_ack);
        n_ack++;
      end
    end
    chk("rr_ack_count", n_ack, 4);
    req_wr = '0;
    @(negedge clk);
    chk("rr_mem0", mem[16'hA000], 8'h10);
    chk("rr_mem1", mem[16'hA001], 8'h21);
    chk("rr_mem2", mem[16'hA002], 8'h32);
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_access(tbl[i]);

    // Timeout: memory never acks a read.
    mem_ack_en = 1'b0;
    req_rd[1] = 1'b1;
    req_addr[16 +: 16] = 16'h0200;
    found = 1'b0;
    ack_c = 0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (c == 16) chk("to_busy_before", busy, 1'b1);
      if (req_ack != 3'b000) begin
        found = 1'b1;
        ack_c = c;
        chk("to_ack_vec", req_ack, 3'b010);
        chk("to_err", req_err, 1'b1);
        chk("to_data", req_dout, 8'hFF);
        req_rd[1] = 1'b0;
      end
    end
    chk("to_ack_cycle", ack_c, 17);
    req_rd[1] = 1'b0;
    @(negedge clk);
    chk("to_busy_after", busy, 1'b0);
    chk("to_err_after", req_err, 1'b0);

    // Wrong-direction ack is ignored; the matching ack later completes.
    req_rd[0] = 1'b1;
    req_addr[0 +: 16] = 16'h1234;
    @(negedge clk);
    chk("wa_strobe", ramb_rd, 1'b1);
    @(negedge clk);
    inj_wr_ack = 1'b1;
    @(negedge clk);
    inj_wr_ack = 1'b0;
    chk("wa_no_ack1", req_ack, 3'b000);
    chk("wa_busy1", busy, 1'b1);
    @(negedge clk);
    chk("wa_no_ack2", req_ack, 3'b000);
    chk("wa_busy2", busy, 1'b1);
    inj_rd_ack = 1'b1;
    @(negedge clk);
    inj_rd_ack = 1'b0;
    chk("wa_ack_vec", req_ack, 3'b001);
    chk("wa_err", req_err, 1'b0);
    chk("wa_data", req_dout, 8'hA5);
    req_rd[0] = 1'b0;
    @(negedge clk);
    chk("wa_busy_after", busy, 1'b0);

    // Reset in the middle of WAIT, then pointer restarts at 0.
    req_rd[1] = 1'b1;
    req_addr[16 +: 16] = 16'h0010;
    for (int c = 0; c < 5; c++) @(negedge clk);
    chk("mr_busy_pre", busy, 1'b1);
    req_wr[0] = 1'b1;
    req_addr[0 +: 16] = 16'h0300;
    req_data[0 +: 8]  = 8'h77;
    req_rd[2] = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("mr_outputs", {req_ack, req_err, req_dout, grant, busy}, '0);
    chk("mr_ramb", {ramb_addr, ramb_rd, ramb_wr, ramb_dout}, '0);
    @(negedge clk);
    chk("mr_no_ack", req_ack, 3'b000);
    reset_n = 1'b1;
    mem_ack_en = 1'b1;
    @(negedge clk);
    chk("mr_strobe_wr", ramb_wr, 1'b1);
    chk("mr_addr", ramb_addr, 16'h0300);
    chk("mr_grant", grant, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("mr_ack_vec", req_ack, 3'b001);
    req_wr = '0;
    req_rd = '0;
    @(negedge clk);
    chk("mr_mem", mem[16'h0300], 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
